burst_addr_seq: RTL
===================

Name: burst_addr_seq

Overview:
Address-burst sequencer that schedules the linear counter datapath feeding TPU buffer reads and writes. It accepts a command (start address, beat count, stride) over a valid/ready handshake. It then emits one address per accepted beat on a backpressured output stream and pulses done when the burst ends. It sits between the TPU control unit and the unified/weight buffer address ports.

Parameters:
ADDR_WIDTH, 32, width of start address, stride and emitted address
LEN_WIDTH, 16, width of beat count; max burst = 2^LEN_WIDTH-1 beats

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted
cmd_start_addr  in  ADDR_WIDTH  first address of burst
cmd_len  in  LEN_WIDTH  number of beats
cmd_stride  in  ADDR_WIDTH  address increment per beat
abort  in  1  terminate running burst
addr_valid  out  1  addr_out is valid
addr_ready  in  1  consumer takes address
addr_out  out  ADDR_WIDTH  current address
addr_last  out  1  current beat is final beat
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-burst pulse

Behaviour:
- States: IDLE, RUN, DONE. Registers: cur_addr, stride_q, remaining.
- Reset (rst=0 at an edge): state=IDLE, cur_addr=0, stride_q=0, remaining=0. All outputs are 0 while rst=0 (cmd_ready is gated by rst).
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: cur_addr<=cmd_start_addr, stride_q<=cmd_stride, remaining<=cmd_len.
  - If cmd_len!=0, go to RUN; otherwise go to DONE.
- RUN: addr_valid=1, addr_out=cur_addr, addr_last=(remaining==1), cmd_ready=0.
  - Beat handshake = addr_valid&&addr_ready.
  - On a handshake: cur_addr<=cur_addr+stride_q, modulo 2^ADDR_WIDTH (silent wrap). remaining<=remaining-1.
  - If addr_last was 1 on that handshake, go to DONE.
  - Without a handshake, addr_out and addr_last hold stable; addr_valid is never withdrawn while in RUN.
- Abort: abort=1 in RUN goes to DONE at the next edge.
  - A handshake in the same cycle as abort still counts.
  - No further addresses are emitted.
  - abort is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle, addr_valid=0, cmd_ready=0. Next state is IDLE.
- Latency:
  - Command accepted at edge N: first addr_valid is high in the cycle after edge N.
  - Last beat handshake at edge M: done is high in the cycle after edge M; cmd_ready returns in the cycle after that.
  - Throughput is one beat per cycle while addr_ready=1.
- busy=1 in RUN and DONE.
- Reset mid-burst: the burst is abandoned with no done pulse; the block is in IDLE on the first cycle after rst returns to 1.
- Zero-length command: no address is emitted; done pulses one cycle after acceptance.

Decomposition:
- tpu_pkg gets: typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t, and default width constants SEQ_ADDR_WIDTH=32 and SEQ_LEN_WIDTH=16.
- One sub-module, burst_addr_ctr, holds cur_addr and remaining. Its controls:
  - load: takes start, len and stride.
  - step: adds stride and decrements remaining.
  - Outputs: addr and is_last.
- The FSM, handshake logic and done pulse stay in burst_addr_seq.

Test Plan:
- Basic burst: cmd 0x100, len 4, stride 1, addr_ready=1 -> addr_out 0x100,0x101,0x102,0x103 on consecutive cycles; addr_last only on 0x103; done one cycle later; cmd_ready high one cycle after done.
- Backpressure: cmd 0x40, len 3, stride 4; addr_ready pattern 1,0,0,1,1 -> beats 0x40,0x44,0x48; addr_out holds 0x44 through both stall cycles; exactly 3 handshakes; one done pulse.
- Zero length and wrap:
  - cmd len 0 -> addr_valid never high; done the cycle after acceptance.
  - cmd 0xFFFFFFFE, len 3, stride 1 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Abort: cmd 0x0, len 10, stride 2; abort asserted with a handshake on beat 3 (addr 0x4) -> exactly 3 beats taken; addr_valid low next cycle; done pulses once; busy drops after done.
- Reset mid-burst: rst=0 for one cycle during beat 2 of a len-5 burst -> all outputs 0 while in reset, no done pulse, cmd_ready=1 right after. A new cmd 0x200 len 1 then yields a single beat 0x200 with addr_last=1.
- Back-to-back commands: cmd_valid held high with two queued commands -> second accepted only after the done cycle; no overlap of addr_valid between bursts.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and default widths for the TPU address sequencing blocks.
//   seq_state_t    : burst sequencer FSM state encoding
//   SEQ_ADDR_WIDTH : default width of addresses and strides
//   SEQ_LEN_WIDTH  : default width of burst beat counts
package tpu_pkg;

  localparam int SEQ_ADDR_WIDTH = 32;
  localparam int SEQ_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/burst_addr_ctr.sv
// Linear address counter for one burst: holds the current address, the
// per-beat stride and the number of beats still to be emitted.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous reset, active-low
//   load    in   capture start/len/stride (takes priority over step)
//   step    in   advance one beat: addr += stride, remaining -= 1
//   start   in   first address of the burst
//   len     in   number of beats
//   stride  in   address increment per beat
//   addr    out  current address
//   is_last out  current beat is the final one (remaining == 1)
module burst_addr_ctr #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_last
);

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  remaining;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_addr  <= '0;
      stride_q  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= start;
      stride_q  <= stride;
      remaining <= len;
    end else if (step) begin
      // Address wraps silently modulo 2^ADDR_WIDTH.
      cur_addr  <= cur_addr + stride_q;
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

  assign addr    = cur_addr;
  assign is_last = (remaining == LEN_WIDTH'(1));

endmodule

// File: rtl/burst_addr_seq.sv
// Address-burst sequencer. Accepts a (start, len, stride) command over a
// valid/ready handshake, emits one address per accepted beat on a
// backpressured stream, and pulses done for one cycle when the burst ends
// (naturally or by abort).
// Ports:
//   clk, rst                  clock and synchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_start_addr, cmd_len,
//   cmd_stride                command payload
//   abort                     end a running burst after the current cycle
//   addr_valid/addr_ready     address stream handshake
//   addr_out, addr_last       address and final-beat flag
//   busy                      burst in progress (RUN or DONE)
//   done                      one-cycle end-of-burst pulse
module burst_addr_seq
  import tpu_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int LEN_WIDTH  = SEQ_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_start_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic                  abort,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            state_reg;
  seq_state_t            state_next;
  logic [ADDR_WIDTH-1:0] ctr_addr;
  logic                  ctr_is_last;
  logic                  cmd_fire;
  logic                  beat_fire;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = addr_valid && addr_ready;

  burst_addr_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .load   (cmd_fire),
    .step   (beat_fire),
    .start  (cmd_start_addr),
    .len    (cmd_len),
    .stride (cmd_stride),
    .addr   (ctr_addr),
    .is_last(ctr_is_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= SEQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEQ_IDLE: begin
        if (cmd_fire) begin
          // A zero-length command skips straight to the done pulse.
          state_next = (cmd_len != '0) ? SEQ_RUN : SEQ_DONE;
        end
      end
      SEQ_RUN: begin
        // A handshake in the abort cycle still counts; the counter steps
        // regardless, only the state leaves RUN.
        if ((beat_fire && ctr_is_last) || abort) begin
          state_next = SEQ_DONE;
        end
      end
      SEQ_DONE: state_next = SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  // Outputs: every output is forced low while reset is asserted so the
  // consumer never sees a stale handshake during reset.
  always_comb begin
    cmd_ready  = 1'b0;
    addr_valid = 1'b0;
    addr_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    addr_out   = '0;
    if (rst) begin
      addr_out = ctr_addr;
      case (state_reg)
        SEQ_IDLE: cmd_ready = 1'b1;
        SEQ_RUN: begin
          addr_valid = 1'b1;
          addr_last  = ctr_is_last;
          busy       = 1'b1;
        end
        SEQ_DONE: begin
          done = 1'b1;
          busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
